// File: rtl/mcu_timer.sv
// Timer/counter peripheral: prescaled up/down counter with compare match,
// one-shot or periodic operation, sticky flag with interrupt, and PWM output.
module mcu_timer #(
    parameter int WIDTH = 16,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] count,
    output logic             match,
    output logic             irq,
    output logic             pwm_out
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COMPARE = 2'd1,
        REG_COUNT   = 2'd2,
        REG_STATUS  = 2'd3
    } reg_addr_e;

    logic             run_q, run_d;
    logic             oneshot_q, oneshot_d;
    logic             down_q, down_d;
    logic             irq_en_q, irq_en_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             flag_q, flag_d;
    logic             match_q, match_d;
    logic             pwm_q, pwm_d;

    logic ctrl_wr, compare_wr, count_wr, status_wr;
    logic running, tick, step, term;

    assign ctrl_wr    = wr_en && (addr == REG_CTRL);
    assign compare_wr = wr_en && (addr == REG_COMPARE);
    assign count_wr   = wr_en && (addr == REG_COUNT);
    assign status_wr  = wr_en && (addr == REG_STATUS);

    assign running = run_q && ena;
    assign tick    = running && (presc_q == pre_q);
    // A COUNT write or a CTRL write that stops the timer pre-empts the step.
    assign step    = tick && !count_wr && !(ctrl_wr && !wr_data[0]);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        count_d = count_q;
        term    = 1'b0;
        if (count_wr) begin
            count_d = wr_data;
        end else if (step) begin
            if (!down_q) begin
                if (count_q == compare_q) begin
                    count_d = '0;
                    term    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = compare_q;
                    term    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        run_d     = run_q;
        oneshot_d = oneshot_q;
        down_d    = down_q;
        irq_en_d  = irq_en_q;
        pre_d     = pre_q;
        compare_d = compare_q;
        if (term && oneshot_q) begin
            run_d = 1'b0;
        end
        if (ctrl_wr) begin
            run_d     = wr_data[0];
            oneshot_d = wr_data[1];
            down_d    = wr_data[2];
            irq_en_d  = wr_data[3];
            pre_d     = wr_data[8 +: PRE_W];
        end
        if (compare_wr) begin
            compare_d = wr_data;
        end

        // Set beats clear when both land on the same edge.
        flag_d = flag_q;
        if (status_wr && wr_data[0]) begin
            flag_d = 1'b0;
        end
        if (term) begin
            flag_d = 1'b1;
        end

        match_d = term;
        pwm_d   = (count_q < compare_q);

        if (!run_d || count_wr || tick) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = presc_q + 1'b1;
        end else begin
            presc_d = presc_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous: rst_n is sampled only at the clock edge.
        if (!rst_n) begin
            run_q     <= 1'b0;
            oneshot_q <= 1'b0;
            down_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            pre_q     <= '0;
            compare_q <= '0;
            count_q   <= '0;
            presc_q   <= '0;
            flag_q    <= 1'b0;
            match_q   <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            run_q     <= run_d;
            oneshot_q <= oneshot_d;
            down_q    <= down_d;
            irq_en_q  <= irq_en_d;
            pre_q     <= pre_d;
            compare_q <= compare_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            flag_q    <= flag_d;
            match_q   <= match_d;
            pwm_q     <= pwm_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_CTRL: begin
                rd_data[0]          = run_q;
                rd_data[1]          = oneshot_q;
                rd_data[2]          = down_q;
                rd_data[3]          = irq_en_q;
                rd_data[8 +: PRE_W] = pre_q;
            end
            REG_COMPARE: rd_data = compare_q;
            REG_COUNT:   rd_data = count_q;
            default:     rd_data[0] = flag_q;
        endcase
    end

    assign count   = count_q;
    assign match   = match_q;
    assign irq     = flag_q & irq_en_q;
    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_mcu_timer.sv
// Directed bench for mcu_timer: per-cycle vector table for reset, up count,
// PWM and flag collisions, then hand-written prescaler/one-shot/reset sequences.
module tb_mcu_timer;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic [15:0] count;
    logic        match;
    logic        irq;
    logic        pwm_out;

    int n_cmp;
    int n_fail;

    mcu_timer #(.WIDTH(16), .PRE_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .count   (count),
        .match   (match),
        .irq     (irq),
        .pwm_out (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ena;
        logic        wr_en;
        logic [1:0]  addr;
        logic [15:0] wr_data;
        logic [15:0] exp_count;
        logic        exp_match;
        logic        exp_irq;
        logic        exp_pwm;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic w,
                       input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        rst_n   = r;
        ena     = e;
        wr_en   = w;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input logic [1:0] a);
        cyc(1'b1, 1'b1, 1'b0, a, 16'h0);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        ena     = 1'b1;
        wr_en   = 1'b0;
        addr    = 2'd0;
        wr_data = 16'h0;

        //            rst  ena  wr    addr  data      count    m     irq   pwm   rd
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 2'd1, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0002};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0003};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 2'd3, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd3, 16'h0000, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 2'd3, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 2'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h0401, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0401};

        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].rst_n, vecs[i].ena, vecs[i].wr_en, vecs[i].addr, vecs[i].wr_data);
            check($sformatf("vec%0d count", i), count, vecs[i].exp_count);
            check($sformatf("vec%0d match", i), match, vecs[i].exp_match);
            check($sformatf("vec%0d irq", i), irq, vecs[i].exp_irq);
            check($sformatf("vec%0d pwm", i), pwm_out, vecs[i].exp_pwm);
            check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd);
        end

        // PRE = 4: one step every 5 enabled cycles after RUN was written.
        for (int k = 1; k <= 12; k++) begin
            idle(2'd2);
            check($sformatf("presc k=%0d count", k), count, 16'(k / 5));
        end
        // Freeze for 7 cycles, then the pending step arrives 7 cycles late.
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd2, 16'h0);
            check($sformatf("ena_low %0d count", k), count, 16'h0002);
        end
        idle(2'd2); check("resume1 count", count, 16'h0002);
        idle(2'd2); check("resume2 count", count, 16'h0002);
        idle(2'd2); check("resume3 count", count, 16'h0003);
        for (int k = 0; k < 4; k++) begin
            idle(2'd2);
            check($sformatf("pre_tick %0d count", k), count, 16'h0003);
        end
        // COUNT write on the tick edge wins and restarts the prescaler.
        wr(2'd2, 16'h0010);
        check("cnt_wr_tick count", count, 16'h0010);
        for (int k = 0; k < 4; k++) begin
            idle(2'd2);
            check($sformatf("after_wr %0d count", k), count, 16'h0010);
        end
        idle(2'd2); check("after_wr step count", count, 16'h0011);

        // Down one-shot with interrupt.
        wr(2'd0, 16'h0000);
        check("stop count", count, 16'h0011);
        wr(2'd3, 16'h0001);
        check("clear flag rd", rd_data, 16'h0000);
        wr(2'd1, 16'h0005);
        wr(2'd2, 16'h0002);
        check("load count", count, 16'h0002);
        wr(2'd0, 16'h000F);
        check("os start count", count, 16'h0002);
        check("os start irq", irq, 1'b0);
        idle(2'd2); check("os c1", count, 16'h0001);
        idle(2'd2); check("os c0", count, 16'h0000);
        idle(2'd0);
        check("os reload count", count, 16'h0005);
        check("os reload match", match, 1'b1);
        check("os reload irq", irq, 1'b1);
        check("os run cleared", rd_data, 16'h000E);
        for (int k = 0; k < 3; k++) begin
            idle(2'd0);
            check($sformatf("os hold %0d count", k), count, 16'h0005);
            check($sformatf("os hold %0d match", k), match, 1'b0);
            check($sformatf("os hold %0d irq", k), irq, 1'b1);
        end
        wr(2'd3, 16'h0001);
        check("os irq cleared", irq, 1'b0);
        check("os still held", count, 16'h0005);

        // CTRL write with RUN=1 on a one-shot terminal edge keeps RUN set.
        wr(2'd2, 16'h0001);
        wr(2'd0, 16'h000F);
        idle(2'd0); check("col c0", count, 16'h0000);
        wr(2'd0, 16'h000F);
        check("col reload count", count, 16'h0005);
        check("col match", match, 1'b1);
        check("col run kept", rd_data, 16'h000F);
        idle(2'd0); check("col continues", count, 16'h0004);
        // Stopping on a tick edge suppresses that step.
        wr(2'd0, 16'h0000);
        check("stop on tick count", count, 16'h0004);

        // Mid-run reset at count 0x1234.
        wr(2'd1, 16'hFFFF);
        wr(2'd2, 16'h1233);
        wr(2'd0, 16'h0001);
        idle(2'd2); check("pre_rst count", count, 16'h1234);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        check("rst count", count, 16'h0000);
        check("rst match", match, 1'b0);
        check("rst irq", irq, 1'b0);
        check("rst pwm", pwm_out, 1'b0);
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            #1;
            check($sformatf("rst reg%0d", a), rd_data, 16'h0000);
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_timer.md
# mcu_timer

Parametrised timer/counter peripheral for the RV32E mini-MCU, replacing the fixed 8-bit free-running counter. It sits on the MCU peripheral register bus and provides:
- a programmable prescaler, up/down counting, and a compare match;
- periodic or one-shot modes;
- a sticky match flag with interrupt, and a PWM output.

All state is in the `clk` domain.

## Interface
Parameters:
- `WIDTH`, 16: counter, compare and data-bus width (8..32).
- `PRE_W`, 8: prescaler width; `PRE_W` ≤ `WIDTH` − 8.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `ena`  in  1  global enable; when low, prescaler and counter hold, and register writes still take effect
- `wr_en`  in  1  register write strobe, one cycle per write
- `addr`  in  2  register address, shared by read and write
- `wr_data`  in  `WIDTH`  write data
- `rd_data`  out  `WIDTH`  combinational read of the register at `addr`
- `count`  out  `WIDTH`  current counter value
- `match`  out  1  registered one-cycle pulse on a terminal event
- `irq`  out  1  `flag & IRQ_EN`, level
- `pwm_out`  out  1  registered `count < COMPARE`

## Operation
Register map:
- 0 `CTRL`, read/write:
  - bit0 `RUN`
  - bit1 `ONESHOT`
  - bit2 `DOWN`
  - bit3 `IRQ_EN`
  - bits [8+`PRE_W`−1:8] `PRE`
  - other bits read 0
- 1 `COMPARE`, read/write.
- 2 `COUNT`, read/write. Reads return the live count; a write loads the counter.
- 3 `STATUS`, bit0 `flag`. Writing 1 to bit0 clears it; writing 0 has no effect.

Reset values: all registers 0, `count` = 0, `match` = 0, `irq` = 0, `pwm_out` = 0, prescaler = 0.

Prescaler:
- Runs only when `RUN & ena`.
- Increments each cycle; when it equals `PRE` it asserts an internal `tick` and wraps to 0.
- One counter step occurs every `PRE`+1 enabled cycles.
- While not running, the prescaler is forced to 0.

Counter step on `tick`:
- Up mode (`DOWN` = 0):
  - If `count == COMPARE`: count ← 0 and a terminal event occurs.
  - Otherwise: count ← count + 1, modulo 2^`WIDTH`.
- Down mode (`DOWN` = 1):
  - If `count == 0`: count ← `COMPARE` and a terminal event occurs.
  - Otherwise: count ← count − 1.

Terminal event:
- `flag` ← 1 and `match` pulses for one cycle.
- If `ONESHOT`, `RUN` ← 0, so the counter stops at its reload value (0 up, `COMPARE` down).

Boundary rules:
- `COMPARE` = 0 gives a terminal event on every tick; the count stays 0.
- A `COUNT` write in the same cycle as a `tick`: the write wins and the prescaler restarts at 0.
- A `CTRL` write that changes `RUN` from 1 to 0 takes effect immediately; no step occurs that cycle.
- A `STATUS` clear in the same cycle as a terminal event: set wins, so `flag` stays 1.
- A `CTRL` write with `RUN` = 1 in the same cycle as a one-shot terminal event: the write wins and `RUN` stays 1.
- `rst_n` low mid-count: all state returns to reset values at the next edge; any pending tick is lost.

## Timing
- Register writes take effect at the `clk` edge where `wr_en` = 1.
- `rd_data` reflects the new value from the following cycle.
- If `CTRL.RUN` is written to 1 at edge N, with the counter previously stopped and `ena` = 1:
  - the first counter step lands at edge N+`PRE`+1;
  - subsequent steps land every `PRE`+1 edges.
- `match`, `flag` and the count reload all update at the same edge; `match` is high for exactly that one following cycle.
- `irq` is combinational from `flag` and `IRQ_EN`, so it rises in the same cycle `flag` reads 1.
- `pwm_out` lags `count` by one cycle.
- Deasserting `ena` freezes the prescaler and counter; they resume from the same values with no lost or extra ticks.

## Test plan
- Reset, then up-periodic count:
  - Stimulus: `COMPARE` = 3, `CTRL` = 0x0001.
  - `count` sequence: 1, 2, 3, 0, 1, … on consecutive edges.
  - `match` pulses at each 3→0 transition; `flag` = 1.
  - With `IRQ_EN` = 0, `irq` = 0.
- Prescaler:
  - Stimulus: `PRE` = 4, up, `COMPARE` = 0xFFFF.
  - `count` increments exactly every 5 cycles.
  - Drop `ena` for 7 cycles: the increment is delayed by exactly 7 cycles.
- Down one-shot:
  - Stimulus: `COMPARE` = 5, write `COUNT` = 2, `CTRL` = 0x000F.
  - `count` goes 1, 0, then 5 with `match`.
  - `RUN` reads 0, `count` holds at 5, and `irq` = 1 until `STATUS` is written with 1.
- Collisions:
  - A `STATUS` clear on the terminal-event cycle leaves `flag` = 1.
  - A `COUNT` = 0x10 write on a tick cycle leaves `count` = 0x10, and the next step comes `PRE`+1 cycles later.
- PWM:
  - Stimulus: `COMPARE` = 3, up, `PRE` = 0.
  - `pwm_out` is high 3 of every 4 cycles, lagging `count` by one cycle.
- Mid-run reset:
  - Stimulus: assert `rst_n` = 0 for one cycle while `count` = 0x1234.
  - All outputs and registers read 0 after that edge.
